// File: rtl/pc_fetch_controller_pkg.sv
// Shared definitions for the PC fetch controller: FSM state encodings and default PC step.
package pc_fetch_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } fetch_state_t;

    localparam int DEFAULT_STEP = 4;

endpackage

// File: rtl/pc_fetch_controller_cla.sv
// N-bit carry-lookahead adder built from 4-bit groups with group generate/propagate.
module nbit_CLA_full_adder #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic         bit_carry;
    logic         group_carry;
    logic         group_gen;
    logic         group_prop;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Carry into each group comes from the previous group's G/P, not from its last bit.
    always_comb begin
        sum         = '0;
        bit_carry   = cin;
        group_carry = cin;
        group_gen   = 1'b0;
        group_prop  = 1'b1;
        for (int base = 0; base < N; base += 4) begin
            bit_carry  = group_carry;
            group_gen  = 1'b0;
            group_prop = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (base + j < N) begin
                    sum[base+j] = prop[base+j] ^ bit_carry;
                    bit_carry   = gen[base+j] | (prop[base+j] & bit_carry);
                    group_gen   = gen[base+j] | (prop[base+j] & group_gen);
                    group_prop  = group_prop & prop[base+j];
                end
            end
            group_carry = group_gen | (group_prop & group_carry);
        end
        cout = group_carry;
    end

endmodule

// File: rtl/pc_fetch_controller.sv
// Instruction fetch controller: owns the PC, a pending-branch register and the IDLE/REQ/HOLD FSM.
module pc_fetch_controller
    import pc_fetch_controller_pkg::*;
#(
    parameter int               WIDTH    = 64,
    parameter int               STEP     = DEFAULT_STEP,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             branch_valid,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] STEP_VEC = WIDTH'(STEP);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_target;
    logic             halt_flag;
    logic             halt_pending;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] next_pc;
    logic             inc_carry_unused;

    nbit_CLA_full_adder #(
        .N(WIDTH)
    ) u_pc_inc (
        .a   (pc),
        .b   (STEP_VEC),
        .cin (1'b0),
        .sum (pc_inc),
        .cout(inc_carry_unused)
    );

    assign halt_pending = halt | halt_flag;

    always_comb begin
        if (branch_valid) begin
            next_pc = branch_target;
        end else if (pend_valid) begin
            next_pc = pend_target;
        end else begin
            next_pc = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Halt outranks stall on an acknowledged fetch; in HOLD it also outranks resuming.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start && !halt_pending) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (halt_pending) begin
                        state_next = IDLE;
                    end else if (stall) begin
                        state_next = HOLD;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            HOLD: begin
                if (halt_pending) begin
                    state_next = IDLE;
                end else if (!stall) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state == REQ);
        busy     = (state != IDLE);
        mem_addr = pc;
    end

    // Outside REQ a branch redirects pc directly; inside an unacked REQ it is parked until the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
            halt_flag   <= 1'b0;
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            halt_flag   <= 1'b0;
            if (state == REQ) begin
                if (mem_ack) begin
                    pc          <= next_pc;
                    fetch_valid <= 1'b1;
                    pend_valid  <= 1'b0;
                end else begin
                    halt_flag <= halt_pending;
                    if (branch_valid) begin
                        pend_valid  <= 1'b1;
                        pend_target <= branch_target;
                    end
                end
            end else if (branch_valid) begin
                pc <= branch_target;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Table-driven, scoreboarded bench for pc_fetch_controller plus a randomized ack-delay sequence.
module tb_pc_fetch_controller;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             halt;
    logic             stall;
    logic             branch_valid;
    logic [WIDTH-1:0] branch_target;
    logic             mem_ack;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             fetch_valid;
    logic [WIDTH-1:0] pc;
    logic             busy;

    always #5 clk = ~clk;

    pc_fetch_controller #(
        .WIDTH   (WIDTH),
        .STEP    (4),
        .RESET_PC('0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .halt         (halt),
        .stall        (stall),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .busy         (busy)
    );

    typedef struct packed {
        logic             rst;
        logic             start;
        logic             halt;
        logic             stall;
        logic             bv;
        logic [WIDTH-1:0] tgt;
        logic             ack;
    } stim_t;

    typedef struct packed {
        logic             req;
        logic [WIDTH-1:0] pc;
        logic             fv;
        logic             busy;
    } want_t;

    typedef struct packed {
        stim_t stim;
        want_t want;
    } vec_t;

    vec_t  table_q[$];
    want_t sb_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    function automatic vec_t mk(input logic rst, st, hl, sl, bv,
                                input logic [WIDTH-1:0] tgt,
                                input logic ack, req,
                                input logic [WIDTH-1:0] epc,
                                input logic fv, bz);
        vec_t v;
        v.stim = '{rst: rst, start: st, halt: hl, stall: sl, bv: bv, tgt: tgt, ack: ack};
        v.want = '{req: req, pc: epc, fv: fv, busy: bz};
        return v;
    endfunction

    task automatic compare(input string tag, input string field,
                           input logic [WIDTH-1:0] actual, input logic [WIDTH-1:0] want);
        tests_run++;
        if (actual !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s %s: got 0x%0h, want 0x%0h", tag, field, actual, want);
        end
    endtask

    // Drive one cycle of inputs, queue what the outputs must be after the edge.
    task automatic applyStimulus(input vec_t v);
        reset         = v.stim.rst;
        start         = v.stim.start;
        halt          = v.stim.halt;
        stall         = v.stim.stall;
        branch_valid  = v.stim.bv;
        branch_target = v.stim.tgt;
        mem_ack       = v.stim.ack;
        sb_q.push_back(v.want);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        want_t w;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s scoreboard: got empty queue, want one entry", tag);
        end else begin
            w = sb_q.pop_front();
            compare(tag, "mem_req", WIDTH'(mem_req), WIDTH'(w.req));
            compare(tag, "mem_addr", mem_addr, w.pc);
            compare(tag, "pc", pc, w.pc);
            compare(tag, "fetch_valid", WIDTH'(fetch_valid), WIDTH'(w.fv));
            compare(tag, "busy", WIDTH'(busy), WIDTH'(w.busy));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        int          pulses;
        logic        seen;
        logic [WIDTH-1:0] seen_pc;

        reset = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
        branch_valid = 1'b0; branch_target = '0; mem_ack = 1'b0;

        //                 rst st hl sl bv tgt                     ack  req pc                      fv bz
        table_q.push_back(mk(1, 0, 0, 0, 0, 64'h0,                  0,   0, 64'h0,                  0, 0));
        table_q.push_back(mk(1, 1, 0, 0, 0, 64'h0,                  1,   0, 64'h0,                  0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  0,   0, 64'h0,                  0, 0));
        table_q.push_back(mk(0, 1, 0, 0, 0, 64'h0,                  0,   1, 64'h0,                  0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  0,   1, 64'h0,                  0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  0,   1, 64'h0,                  0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  0,   1, 64'h0,                  0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'h4,                  1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'h8,                  1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'hC,                  1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 1, 64'h100,                0,   1, 64'hC,                  0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  0,   1, 64'hC,                  0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'h100,                1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'h104,                1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 1, 64'h200,                0,   1, 64'h104,                0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 1, 64'h300,                0,   1, 64'h104,                0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'h300,                1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 1, 64'h400,                1,   1, 64'h400,                1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 1, 64'h500,                0,   1, 64'h400,                0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 1, 64'h600,                1,   1, 64'h600,                1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'h604,                1, 1));
        table_q.push_back(mk(0, 0, 0, 1, 0, 64'h0,                  1,   0, 64'h608,                1, 1));
        table_q.push_back(mk(0, 0, 0, 1, 0, 64'h0,                  0,   0, 64'h608,                0, 1));
        table_q.push_back(mk(0, 0, 0, 1, 1, 64'h800,                0,   0, 64'h800,                0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  0,   1, 64'h800,                0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'h804,                1, 1));
        table_q.push_back(mk(0, 0, 1, 0, 0, 64'h0,                  0,   1, 64'h804,                0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  0,   1, 64'h804,                0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   0, 64'h808,                1, 0));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  0,   0, 64'h808,                0, 0));
        table_q.push_back(mk(0, 1, 1, 0, 0, 64'h0,                  0,   0, 64'h808,                0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 1, 64'h10,                 0,   0, 64'h10,                 0, 0));
        table_q.push_back(mk(0, 1, 0, 0, 0, 64'h0,                  0,   1, 64'h10,                 0, 1));
        table_q.push_back(mk(0, 0, 1, 1, 0, 64'h0,                  1,   0, 64'h14,                 1, 0));
        table_q.push_back(mk(0, 1, 0, 0, 0, 64'h0,                  0,   1, 64'h14,                 0, 1));
        table_q.push_back(mk(0, 0, 0, 1, 0, 64'h0,                  1,   0, 64'h18,                 1, 1));
        table_q.push_back(mk(0, 0, 1, 0, 0, 64'h0,                  0,   0, 64'h18,                 0, 0));
        table_q.push_back(mk(0, 1, 0, 0, 0, 64'h0,                  0,   1, 64'h18,                 0, 1));
        table_q.push_back(mk(0, 1, 0, 0, 0, 64'h0,                  0,   1, 64'h18,                 0, 1));
        table_q.push_back(mk(1, 0, 0, 0, 0, 64'h0,                  1,   0, 64'h0,                  0, 0));
        table_q.push_back(mk(0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0,  0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0));
        table_q.push_back(mk(0, 1, 0, 0, 0, 64'h0,                  0,   1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'h0,                  1, 1));
        table_q.push_back(mk(0, 0, 0, 0, 0, 64'h0,                  1,   1, 64'h4,                  1, 1));

        foreach (table_q[i]) begin
            applyStimulus(table_q[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Random-length ack delay, then a single ack whose pulse is awaited under a cycle bound.
        applyStimulus(mk(1, 0, 0, 0, 0, 64'h0, 0, 0, 64'h0, 0, 0));
        checkOutput("seq_reset");
        applyStimulus(mk(0, 1, 0, 0, 0, 64'h0, 0, 1, 64'h0, 0, 1));
        checkOutput("seq_start");
        n = $urandom_range(1, 5);
        for (int k = 0; k < n; k++) begin
            applyStimulus(mk(0, 0, 0, 0, 0, 64'h0, 0, 1, 64'h0, 0, 1));
            checkOutput($sformatf("seq_wait%0d", k));
        end
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        seen    = 1'b0;
        pulses  = 0;
        seen_pc = '1;
        for (int c = 0; c < 6; c++) begin
            if (fetch_valid) begin
                pulses++;
                if (!seen) seen_pc = pc;
                seen = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        compare("seq_ack", "fetch_valid_seen", WIDTH'(seen), WIDTH'(1'b1));
        compare("seq_ack", "fetch_valid_pulses", WIDTH'(pulses), WIDTH'(1));
        compare("seq_ack", "pc_at_pulse", seen_pc, 64'h4);
        compare("seq_ack", "mem_req_after", WIDTH'(mem_req), WIDTH'(1'b1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
